// File: rtl/jt12_bus_writer.sv
// Purpose : queues (port, reg, value) writes and replays each one as the YM two-phase
//           address/data bus write, then polls busy or waits a fixed gap.
// Latency : a push into an empty, idle block drives cs_n low at the 2nd cen edge after the push.
// Backpr. : req_ready = FIFO not full; a push attempted while full is dropped.
//
// Ports:
//   clk, rst (async, active high), cen (state advances only when 1)
//   req_valid/req_ready/req_port/req_reg/req_val : request push interface
//   addr, din, cs_n, wr_n : registered chip bus outputs; dout : chip status (bit 7 = busy)
//   level : FIFO occupancy; active : busy or work pending
//   timeout : sticky busy-poll timeout flag; clr_timeout clears it (a set wins)

module jt12_bus_writer_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 17
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_vld,
    output logic                       push_rdy,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               pop_dat,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int LW = $clog2(DEPTH);
    localparam logic [LW:0] FULL_CNT = (LW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [LW-1:0] wr_ptr_q;
    logic [LW-1:0] rd_ptr_q;
    logic [LW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign push_rdy = (cnt_q != FULL_CNT);
    assign empty    = (cnt_q == '0);
    assign level    = cnt_q;
    assign pop_dat  = mem_q[rd_ptr_q];
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop && !empty;

    // Storage has no reset: contents are only meaningful below the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

module jt12_bus_writer #(
    parameter int DEPTH    = 16,
    parameter int WR_LEN   = 2,
    parameter int GAP      = 4,
    parameter int USE_BUSY = 1,
    parameter int TIMEOUT  = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cen,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_port,
    input  logic [7:0]             req_reg,
    input  logic [7:0]             req_val,
    output logic [1:0]             addr,
    output logic [7:0]             din,
    output logic                   cs_n,
    output logic                   wr_n,
    input  logic [7:0]             dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   active,
    output logic                   timeout,
    input  logic                   clr_timeout
);
    typedef struct packed {
        logic       port;
        logic [7:0] rg;
        logic [7:0] val;
    } wr_req_t;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AW   = 3'd1;
    localparam logic [2:0] ST_AG   = 3'd2;
    localparam logic [2:0] ST_DW   = 3'd3;
    localparam logic [2:0] ST_DG   = 3'd4;
    localparam logic [2:0] ST_BSY  = 3'd5;

    localparam logic [3:0]  WR_LEN_M1 = 4'(WR_LEN - 1);
    localparam logic [7:0]  GAP_M1    = 8'(GAP - 1);
    localparam logic [15:0] TMO_M1    = 16'(TIMEOUT - 1);

    logic [2:0]  state_q,   state_d;
    logic [3:0]  ph_cnt_q,  ph_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    wr_req_t     ent_q,     ent_d;
    logic [1:0]  addr_q;
    logic [7:0]  din_q;
    logic        cs_n_q;
    logic        wr_n_q;
    logic        timeout_q;

    logic        fifo_pop;
    logic        fifo_empty;
    wr_req_t     fifo_dat;
    wr_req_t     push_req;
    logic        tmo_set;
    logic        busy;
    logic        unused_dout;

    assign push_req    = '{port: req_port, rg: req_reg, val: req_val};
    assign busy        = dout[7];
    assign unused_dout = ^dout[6:0];

    jt12_bus_writer_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(wr_req_t))
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (req_valid),
        .push_rdy (req_ready),
        .push_dat (push_req),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .empty    (fifo_empty),
        .level    (level)
    );

    // Next-state logic; every counter is cleared on entry to the state that uses it,
    // and the compare-before-increment keeps it from ever wrapping.
    always_comb begin
        state_d   = state_q;
        ph_cnt_d  = ph_cnt_q;
        gap_cnt_d = gap_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        ent_d     = ent_q;
        fifo_pop  = 1'b0;
        tmo_set   = 1'b0;
        if (cen) begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        ent_d    = fifo_dat;
                        ph_cnt_d = '0;
                        state_d  = ST_AW;
                    end
                end
                ST_AW: begin
                    if (ph_cnt_q >= WR_LEN_M1) begin
                        gap_cnt_d = '0;
                        state_d   = ST_AG;
                    end else begin
                        ph_cnt_d = ph_cnt_q + 4'd1;
                    end
                end
                ST_AG: begin
                    if (gap_cnt_q >= GAP_M1) begin
                        ph_cnt_d = '0;
                        state_d  = ST_DW;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 8'd1;
                    end
                end
                ST_DW: begin
                    if (ph_cnt_q >= WR_LEN_M1) begin
                        gap_cnt_d = '0;
                        state_d   = ST_DG;
                    end else begin
                        ph_cnt_d = ph_cnt_q + 4'd1;
                    end
                end
                ST_DG: begin
                    if (gap_cnt_q >= GAP_M1) begin
                        tmo_cnt_d = '0;
                        state_d   = (USE_BUSY != 0) ? ST_BSY : ST_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 8'd1;
                    end
                end
                ST_BSY: begin
                    if (!busy) begin
                        state_d = ST_IDLE;
                    end else if (tmo_cnt_q >= TMO_M1) begin
                        tmo_set = 1'b1;
                        state_d = ST_IDLE;
                    end else if (tmo_cnt_q != 16'hFFFF) begin
                        tmo_cnt_d = tmo_cnt_q + 16'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ph_cnt_q  <= '0;
            gap_cnt_q <= '0;
            tmo_cnt_q <= '0;
            ent_q     <= '0;
        end else begin
            state_q   <= state_d;
            ph_cnt_q  <= ph_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            ent_q     <= ent_d;
        end
    end

    // Bus outputs are decoded from the current state into flops, so the pins trail the
    // state by one cen cycle and are glitch free. addr/din hold outside the write phases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= 2'b00;
            din_q  <= 8'h00;
            cs_n_q <= 1'b1;
            wr_n_q <= 1'b1;
        end else if (cen) begin
            case (state_q)
                ST_AW: begin
                    addr_q <= {ent_q.port, 1'b0};
                    din_q  <= ent_q.rg;
                    cs_n_q <= 1'b0;
                    wr_n_q <= 1'b0;
                end
                ST_DW: begin
                    addr_q <= {ent_q.port, 1'b1};
                    din_q  <= ent_q.val;
                    cs_n_q <= 1'b0;
                    wr_n_q <= 1'b0;
                end
                ST_BSY: begin
                    addr_q <= 2'b00;
                    cs_n_q <= 1'b0;
                    wr_n_q <= 1'b1;
                end
                default: begin
                    cs_n_q <= 1'b1;
                    wr_n_q <= 1'b1;
                end
            endcase
        end
    end

    // Clear is honoured on any clk edge; a timeout set in the same cycle takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (tmo_set) begin
            timeout_q <= 1'b1;
        end else if (clr_timeout) begin
            timeout_q <= 1'b0;
        end
    end

    assign addr    = addr_q;
    assign din     = din_q;
    assign cs_n    = cs_n_q;
    assign wr_n    = wr_n_q;
    assign timeout = timeout_q;
    assign active  = (state_q != ST_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_jt12_bus_writer.sv
// Bench for jt12_bus_writer: two instances (fixed-gap DEPTH=8, busy-poll DEPTH=4 TIMEOUT=20),
// stimulus pushes expected bus phases into per-instance queues, monitors pop and compare.
// All durations are measured in cen cycles.

module tb_jt12_bus_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cen_mode = 0;
    int cen_ph = 0;

    logic       rv0 = 1'b0, rp0 = 1'b0, clr0 = 1'b0;
    logic [7:0] rr0 = 8'h00, rvl0 = 8'h00, dout0 = 8'h00;
    logic       ready0, cs0, wr0, act0, to0;
    logic [1:0] addr0;
    logic [7:0] din0;
    logic [3:0] level0;

    logic       rv1 = 1'b0, rp1 = 1'b0, clr1 = 1'b0;
    logic [7:0] rr1 = 8'h00, rvl1 = 8'h00, dout1 = 8'h00;
    logic       ready1, cs1, wr1, act1, to1;
    logic [1:0] addr1;
    logic [7:0] din1;
    logic [2:0] level1;

    int busy_cnt = 0;
    int busy_len = 10;
    logic [9:0] exp0[$];
    logic [9:0] exp1[$];
    int rd_run0 = 0, rd_run1 = 0, fall0 = 0, fall1 = 0;

    logic [1:0] m_addr[2];
    logic [7:0] m_din[2];
    logic       m_cs[2], m_wr[2], m_act[2];
    assign m_addr[0] = addr0; assign m_addr[1] = addr1;
    assign m_din[0]  = din0;  assign m_din[1]  = din1;
    assign m_cs[0]   = cs0;   assign m_cs[1]   = cs1;
    assign m_wr[0]   = wr0;   assign m_wr[1]   = wr1;
    assign m_act[0]  = act0;  assign m_act[1]  = act1;

    jt12_bus_writer #(.DEPTH(8), .WR_LEN(2), .GAP(4), .USE_BUSY(0), .TIMEOUT(1023)) u0 (
        .clk(clk), .rst(rst), .cen(cen), .req_valid(rv0), .req_ready(ready0),
        .req_port(rp0), .req_reg(rr0), .req_val(rvl0), .addr(addr0), .din(din0),
        .cs_n(cs0), .wr_n(wr0), .dout(dout0), .level(level0), .active(act0),
        .timeout(to0), .clr_timeout(clr0)
    );

    jt12_bus_writer #(.DEPTH(4), .WR_LEN(2), .GAP(4), .USE_BUSY(1), .TIMEOUT(20)) u1 (
        .clk(clk), .rst(rst), .cen(cen), .req_valid(rv1), .req_ready(ready1),
        .req_port(rp1), .req_reg(rr1), .req_val(rvl1), .addr(addr1), .din(din1),
        .cs_n(cs1), .wr_n(wr1), .dout(dout1), .level(level1), .active(act1),
        .timeout(to1), .clr_timeout(clr1)
    );

    task automatic check(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, expv);
        end
    endtask

    // cen pattern: 0 = always on, 1 = one cycle in three, 2 = off.
    initial begin
        forever begin
            @(negedge clk);
            cen_ph = cen_ph + 1;
            case (cen_mode)
                0:       cen = 1'b1;
                1:       cen = ((cen_ph % 3) == 0);
                default: cen = 1'b0;
            endcase
        end
    end

    // Chip busy model for instance 1: busy reloads during each data write and counts down per cen.
    initial begin : busy_model
        bit c;
        forever begin
            @(posedge clk);
            c = cen;
            #1;
            if (c && !rst) begin
                if (!wr1 && addr1[0]) busy_cnt = busy_len;
                else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
            end
            dout1 = (busy_cnt != 0) ? 8'h80 : 8'h00;
        end
    end

    task automatic mon(input int k);
        bit c, prev_wr, trk, has;
        int low_len, hi_len, post_len, rd;
        logic [9:0] e;
        prev_wr = 1'b1; trk = 1'b0; low_len = 0; hi_len = 0; post_len = 0; rd = 0; e = '0;
        forever begin
            @(posedge clk);
            c = cen;
            #2;
            if (rst) begin
                prev_wr = 1'b1; trk = 1'b0; low_len = 0; hi_len = 0; rd = 0;
                if (k == 0) rd_run0 = 0; else rd_run1 = 0;
            end else if (c) begin
                if (!m_wr[k]) begin
                    if (prev_wr) begin
                        trk = 1'b0;
                        low_len = 0;
                        if (k == 0) begin
                            fall0++;
                            has = (exp0.size() > 0);
                            if (has) e = exp0.pop_front();
                        end else begin
                            fall1++;
                            has = (exp1.size() > 0);
                            if (has) e = exp1.pop_front();
                        end
                        check($sformatf("u%0d write was expected", k), int'(has), 1);
                        if (has) begin
                            check($sformatf("u%0d addr", k), int'(m_addr[k]), int'(e[9:8]));
                            check($sformatf("u%0d din", k), int'(m_din[k]), int'(e[7:0]));
                        end
                        if (m_addr[k][0]) check($sformatf("u%0d addr-data gap", k), hi_len, 4);
                        else if (k == 1) check("u1 pop while busy", int'(busy_cnt != 0), 0);
                    end
                    low_len++;
                end else begin
                    if (!prev_wr) begin
                        check($sformatf("u%0d wr_n low length", k), low_len, 2);
                        hi_len = 0;
                        if (m_addr[k][0]) begin
                            rd = 0;
                            trk = (k == 0);
                            post_len = 0;
                        end
                    end
                    hi_len++;
                    if (!m_cs[k]) rd++;
                    if (trk) begin
                        post_len++;
                        if (!m_act[k]) begin
                            check("u0 active drop after data", post_len, 4);
                            trk = 1'b0;
                        end
                    end
                    if (k == 0) rd_run0 = rd; else rd_run1 = rd;
                end
                prev_wr = m_wr[k];
            end
        end
    endtask

    initial mon(0);
    initial mon(1);

    task automatic push(input int k, input logic p, input logic [7:0] r, input logic [7:0] v,
                        input bit acc);
        @(negedge clk);
        if (k == 0) begin rv0 = 1'b1; rp0 = p; rr0 = r; rvl0 = v; end
        else        begin rv1 = 1'b1; rp1 = p; rr1 = r; rvl1 = v; end
        if (acc) begin
            if (k == 0) begin exp0.push_back({p, 1'b0, r}); exp0.push_back({p, 1'b1, v}); end
            else        begin exp1.push_back({p, 1'b0, r}); exp1.push_back({p, 1'b1, v}); end
        end
        @(negedge clk);
        rv0 = 1'b0;
        rv1 = 1'b0;
    endtask

    task automatic drain(input int k, input int max_cyc);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < max_cyc) begin
            @(posedge clk);
            #3;
            n++;
            if (k == 0) done = (exp0.size() == 0) && !act0;
            else        done = (exp1.size() == 0) && !act1;
        end
        check($sformatf("u%0d drained within %0d cycles", k, max_cyc), int'(done), 1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n, f;
        bit hit;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset cs_n", int'(cs0), 1);
        check("reset wr_n", int'(wr0), 1);
        check("reset addr", int'(addr0), 0);
        check("reset din", int'(din0), 0);
        check("reset level", int'(level0), 0);
        check("reset active", int'(act0), 0);
        check("reset timeout", int'(to1), 0);
        check("reset u1 cs_n", int'(cs1), 1);
        rst = 1'b0;
        @(negedge clk);
        check("req_ready after reset u0", int'(ready0), 1);
        check("req_ready after reset u1", int'(ready1), 1);

        // Single write, fixed gap
        push(0, 1'b0, 8'h28, 8'hF0, 1'b1);
        n = 0;
        hit = 1'b0;
        while (!hit && n < 20) begin
            @(posedge clk);
            #2;
            n++;
            hit = !cs0;
        end
        check("push to cs_n low latency", n, 2);
        drain(0, 200);

        // Same traffic with cen one cycle in three
        cen_mode = 1;
        push(0, 1'b0, 8'hA4, 8'h22, 1'b1);
        push(0, 1'b1, 8'h30, 8'h71, 1'b1);
        drain(0, 600);
        cen_mode = 0;

        // Reset in the middle of a data phase with entries queued
        for (int i = 0; i < 5; i++) push(0, 1'b0, 8'h40 + 8'(i), 8'h10 + 8'(i), 1'b1);
        n = 0;
        hit = 1'b0;
        while (!hit && n < 200) begin
            @(posedge clk);
            #3;
            n++;
            hit = !wr0 && addr0[0];
        end
        check("reached data phase before reset", int'(hit), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async reset cs_n", int'(cs0), 1);
        check("async reset wr_n", int'(wr0), 1);
        check("async reset level", int'(level0), 0);
        exp0.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        f = fall0;
        repeat (150) @(posedge clk);
        #3;
        check("no bus activity after reset", fall0, f);
        check("level after reset", int'(level0), 0);
        check("active after reset", int'(act0), 0);

        // Port 1 with busy held for 10 cen cycles after the data write
        busy_len = 10;
        push(1, 1'b1, 8'hB4, 8'hC0, 1'b1);
        push(1, 1'b1, 8'hB5, 8'h3F, 1'b1);
        drain(1, 400);
        check("status reads until busy clears", rd_run1, 7);
        check("no timeout on busy poll", int'(to1), 0);

        // Busy stuck: timeout after 20 polls, next entry still written
        busy_len = 1000;
        push(1, 1'b0, 8'h22, 8'h08, 1'b1);
        push(1, 1'b0, 8'h27, 8'h15, 1'b1);
        n = 0;
        while (!to1 && n < 600) begin
            @(posedge clk);
            #3;
            n++;
        end
        check("timeout raised", int'(to1), 1);
        check("status reads before timeout", rd_run1, 20);
        busy_len = 3;
        busy_cnt = 0;
        drain(1, 400);
        check("timeout sticky", int'(to1), 1);
        @(negedge clk);
        clr1 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0;
        check("timeout cleared", int'(to1), 0);

        // Full FIFO while cen is held low
        busy_len = 2;
        cen_mode = 2;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) push(1, 1'(i % 2), 8'h60 + 8'(i), 8'hE0 + 8'(i), (i < 4));
        check("full level", int'(level1), 4);
        check("full req_ready", int'(ready1), 0);
        check("cen low bus frozen", int'(cs1), 1);
        cen_mode = 0;
        drain(1, 1000);
        check("level after full drain", int'(level1), 0);

        repeat (5) @(posedge clk);
        check("u0 expectations left", exp0.size(), 0);
        check("u1 expectations left", exp1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/jt12_bus_writer.md
# jt12_bus_writer

Parametrised register-write sequencer that sits between a host or testbench and the `jt12_top` CPU bus. It queues (port, register, value) requests in a FIFO and replays each one as the two-phase address/data write the YM chips expect. Between writes it either polls the status busy flag (`dout[7]`) or waits a fixed gap, with a timeout. It replaces hand-timed `cs_n`/`wr_n` stimulus, so the same sequencer drives YM2203, YM2610 and YM2612 configurations.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `WR_LEN`, 2: `cen` cycles that `cs_n`/`wr_n` stay low per write phase; 1..15.
- `GAP`, 4: `cen` cycles with `cs_n` high after each phase; 1..255.
- `USE_BUSY`, 1: 1 = poll `dout[7]` after the data phase; 0 = fixed wait of `GAP` cycles.
- `TIMEOUT`, 1023: maximum busy-poll `cen` cycles before giving up; 1..65535.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cen`  in  1  clock enable; state advances only when `cen`=1.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  FIFO not full.
- `req_port`  in  1  register bank (0 = addr 0/1, 1 = addr 2/3).
- `req_reg`  in  8  register number.
- `req_val`  in  8  register value.
- `addr`  out  2  chip address bus.
- `din`  out  8  chip data bus (the chip's `din`).
- `cs_n`  out  1  chip select, active low.
- `wr_n`  out  1  write strobe, active low.
- `dout`  in  8  chip status; bit 7 = busy.
- `level`  out  log2(DEPTH)+1  FIFO occupancy.
- `active`  out  1  high when FSM is not IDLE or FIFO is non-empty.
- `timeout`  out  1  sticky; set when a busy poll exceeds `TIMEOUT`.
- `clr_timeout`  in  1  clears `timeout`; a set in the same cycle wins.

## Operation
- **Push:** a push happens when `req_valid && req_ready` on any `clk` edge, independent of `cen`. `req_ready` = !full, combinational from the count.
- **Pop:** occurs when the FSM leaves IDLE. A simultaneous push and pop leaves `level` unchanged. A push when full is dropped, because `req_ready` is low.
- **FSM** (transitions on `cen`):
  - IDLE: if the FIFO is non-empty, pop the entry, latch it, go to AW.
  - AW: `addr`={port,0}, `din`=reg, `cs_n`=0, `wr_n`=0 for `WR_LEN` cycles, then AG.
  - AG: `cs_n`=1, `wr_n`=1 for `GAP` cycles, then DW.
  - DW: `addr`={port,1}, `din`=val, `cs_n`=0, `wr_n`=0 for `WR_LEN` cycles, then DG.
  - DG: `cs_n`=1, `wr_n`=1 for `GAP` cycles. Then go to BSY if `USE_BUSY`, else IDLE.
  - BSY: `addr`=0, `cs_n`=0, `wr_n`=1 (status read). Sample `dout[7]` each `cen`. On 0, go to IDLE. If the counter reaches `TIMEOUT`, set `timeout` and go to IDLE.
- `addr`/`din` hold their last values outside the write states.
- IDLE takes one `cen` to pop. Back-to-back entries therefore have one idle cycle between them.
- All bus outputs are registered. There are no glitches on `cs_n`/`wr_n`.
- Counters are sized to their parameter. The phase counter is 4 bits, the gap counter 8 bits, the timeout counter 16 bits. All counters saturate and never wrap.

## Timing
- **Reset values:** `cs_n`=1, `wr_n`=1, `addr`=0, `din`=0, `level`=0, `active`=0, `timeout`=0, FSM=IDLE, FIFO pointers=0. `req_ready`=1 once `rst` is released.
- **Reset mid-operation:** the bus returns to idle asynchronously and FIFO contents are discarded.
- **Latency:** a push into an empty idle block gives `cs_n` low at the 2nd `cen` edge after the push edge.
- **Write duration without busy:**
  - Per write: 2·`WR_LEN`+2·`GAP` `cen` cycles.
  - Between consecutive writes: 2·`WR_LEN`+2·`GAP`+1 cycles from one AW start to the next.
- **`cen` low:** all FSM state and outputs freeze; pushes still accepted.
- **`active`:** drops in the same cycle FSM enters IDLE with the FIFO empty.

## Test plan
- **Reset:** assert `rst` mid-DW with 5 entries queued. Required: `cs_n`=`wr_n`=1 immediately, `level`=0, and no further bus activity after release.
- **Single write** (`USE_BUSY`=0, `WR_LEN`=2, `GAP`=4), push {0,8'h28,8'hF0}. Required:
  - `addr`=0, `din`=28 with `wr_n` low for 2 cycles;
  - 4 idle cycles;
  - `addr`=1, `din`=F0 low for 2 cycles;
  - then `active`=0 after 4 more.
- **Port 1 busy poll:** push {1,8'hB4,8'hC0}, model holds `dout[7]`=1 for 10 `cen`. Required: `addr` 2 then 3, status reads continue until busy clears, next pop only after busy clears, `timeout`=0.
- **Timeout** with `TIMEOUT`=20 and busy stuck at 1. Required: `timeout` set after 20 poll cycles, the next queued entry is written, and `clr_timeout` clears it.
- **Full FIFO** (`DEPTH`=4): push 6 entries with `cen`=0. Required: `level`=4, `req_ready`=0, and only the first 4 are written in order once `cen`=1.
- **`cen` gating:** run with `cen` toggling 1-of-3. Required: identical bus sequence and counts measured in `cen` cycles.
